// File: rtl/dadda_err_monitor_if.sv
// Sample/handshake and result bundle between a multiplier-under-test source and the
// error monitor.
interface dadda_err_monitor_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic [2*WIDTH-1:0]   prod;
    logic                 busy;
    logic                 done;
    logic [8:0]           err_count;
    logic [2*WIDTH-1:0]   max_ed;
    logic [2*WIDTH+8:0]   sum_ed;

    modport master (
        output start, in_valid, in1, in2, prod,
        input  in_ready, busy, done, err_count, max_ed, sum_ed
    );

    modport slave (
        input  start, in_valid, in1, in2, prod,
        output in_ready, busy, done, err_count, max_ed, sum_ed
    );
endinterface

// File: rtl/dadda_err_monitor.sv
// Measures the error of an approximate multiplier over a run of NSAMPLES samples:
// counts erroneous samples, tracks the largest error distance and sums all distances.
module dadda_err_monitor #(
    parameter int WIDTH    = 4,
    parameter int NSAMPLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    dadda_err_monitor_if.slave  bus
);
    localparam int          PW        = 2 * WIDTH;
    localparam int          SW        = 2 * WIDTH + 9;
    localparam logic [8:0]  LAST_IDX  = 9'(NSAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [8:0]        r_count;
    logic [8:0]        r_errCount;
    logic [PW-1:0]     r_maxEd;
    logic [SW-1:0]     r_sumEd;

    logic [PW-1:0]     w_opA;
    logic [PW-1:0]     w_opB;
    logic [PW-1:0]     w_exact;
    logic [PW-1:0]     w_ed;
    logic              w_inRun;
    logic              w_accept;
    logic              w_last;
    logic              w_startRun;

    // Operands are zero-extended so the exact product never wraps at PW bits.
    assign w_opA    = {{WIDTH{1'b0}}, bus.in1};
    assign w_opB    = {{WIDTH{1'b0}}, bus.in2};
    assign w_exact  = w_opA * w_opB;
    assign w_ed     = (w_exact >= bus.prod) ? (w_exact - bus.prod) : (bus.prod - w_exact);

    assign w_inRun    = (r_state == RUN);
    assign w_accept   = bus.in_valid && w_inRun;
    assign w_last     = w_accept && (r_count == LAST_IDX);
    assign w_startRun = bus.start && !w_inRun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A start that opens a run wins over any sample in the same cycle; none is accepted outside RUN anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_errCount <= '0;
            r_maxEd    <= '0;
            r_sumEd    <= '0;
        end else if (w_startRun) begin
            r_count    <= '0;
            r_errCount <= '0;
            r_maxEd    <= '0;
            r_sumEd    <= '0;
        end else if (w_accept) begin
            r_count    <= r_count + 9'd1;
            r_errCount <= r_errCount + {8'd0, |w_ed};
            r_sumEd    <= r_sumEd + {9'd0, w_ed};
            if (w_ed > r_maxEd) begin
                r_maxEd <= w_ed;
            end
        end
    end

    assign bus.in_ready  = w_inRun;
    assign bus.busy      = w_inRun;
    assign bus.done      = (r_state == DONE);
    assign bus.err_count = r_errCount;
    assign bus.max_ed    = r_maxEd;
    assign bus.sum_ed    = r_sumEd;
endmodule

// File: tb/tb_dadda_err_monitor.sv
// Self-checking bench for dadda_err_monitor: directed scenarios plus randomized runs
// compared against a plain-arithmetic model of the error statistics.
module tb_dadda_err_monitor;
    localparam int W  = 4;
    localparam int NS = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    int   mErr;
    int   mMax;
    int   mSum;
    int   mAcc;
    bit   mRun;

    dadda_err_monitor_if #(.WIDTH(W)) bus4 ();
    dadda_err_monitor_if #(.WIDTH(W)) bus256 ();

    dadda_err_monitor #(.WIDTH(W), .NSAMPLES(NS)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    dadda_err_monitor #(.WIDTH(W), .NSAMPLES(256)) dut256 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int edOf(input int a, input int b, input int p);
        int ex;
        ex = a * b;
        return (ex >= p) ? (ex - p) : (p - ex);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart4();
        bus4.start    = 1'b1;
        bus4.in_valid = 1'b0;
        tick();
        bus4.start = 1'b0;
        if (!mRun) begin
            mErr = 0; mMax = 0; mSum = 0; mAcc = 0; mRun = 1'b1;
        end
    endtask

    task automatic send4(input bit v, input int a, input int b, input int p);
        int e;
        bus4.in_valid = v;
        bus4.in1      = 4'(a);
        bus4.in2      = 4'(b);
        bus4.prod     = 8'(p);
        tick();
        bus4.in_valid = 1'b0;
        if (v && mRun) begin
            e = edOf(a, b, p);
            if (e != 0) mErr++;
            mSum += e;
            if (e > mMax) mMax = e;
            mAcc++;
            if (mAcc == NS) mRun = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        if ({bus4.in_ready, bus4.busy, bus4.done} !== 3'b000 || bus4.err_count !== 9'd0 ||
            bus4.max_ed !== 8'd0 || bus4.sum_ed !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_state ready/busy/done=%b%b%b err=%0d max=%0d sum=%0d expected all 0",
                     bus4.in_ready, bus4.busy, bus4.done, bus4.err_count, bus4.max_ed, bus4.sum_ed);
        end
        checks++;
        #20 rst_n = 1'b1;
        tick();
        pulseStart4();
        if (bus4.busy !== 1'b1 || bus4.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_start busy=%b ready=%b expected 1 1", bus4.busy, bus4.in_ready);
        end
        checks++;
        send4(1, 15, 15, 200);
        if (bus4.err_count !== 9'd1 || bus4.sum_ed !== 17'd25 || bus4.max_ed !== 8'd25) begin
            failures++;
            $display("[TB] FAIL reset_prerun err=%0d max=%0d sum=%0d expected 1 25 25",
                     bus4.err_count, bus4.max_ed, bus4.sum_ed);
        end
        checks++;
        #3 rst_n = 1'b0;
        mRun = 1'b0;
        #1;
        if ({bus4.in_ready, bus4.busy, bus4.done} !== 3'b000 || bus4.err_count !== 9'd0 ||
            bus4.max_ed !== 8'd0 || bus4.sum_ed !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_async ready/busy/done=%b%b%b err=%0d max=%0d sum=%0d expected all 0",
                     bus4.in_ready, bus4.busy, bus4.done, bus4.err_count, bus4.max_ed, bus4.sum_ed);
        end
        checks++;
        #2 rst_n = 1'b1;
        send4(1, 3, 3, 0);
        send4(1, 3, 3, 0);
        if (bus4.busy !== 1'b0 || bus4.in_ready !== 1'b0 || bus4.err_count !== 9'd0) begin
            failures++;
            $display("[TB] FAIL reset_idle busy=%b ready=%b err=%0d expected 0 0 0",
                     bus4.busy, bus4.in_ready, bus4.err_count);
        end
        checks++;
    endtask

    task automatic test_exact_stream();
        pulseStart4();
        for (int i = 0; i < NS; i++) begin
            send4(1, 15, 1, 15);
            if (bus4.done !== (i == NS - 1)) begin
                failures++;
                $display("[TB] FAIL exact_done sample=%0d done=%b expected %b", i, bus4.done, (i == NS - 1));
            end
            checks++;
        end
        if (bus4.err_count !== 9'd0 || bus4.max_ed !== 8'd0 || bus4.sum_ed !== 17'd0 || bus4.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL exact_stats err=%0d max=%0d sum=%0d busy=%b expected 0 0 0 0",
                     bus4.err_count, bus4.max_ed, bus4.sum_ed, bus4.busy);
        end
        checks++;
    endtask

    task automatic test_error_mix();
        pulseStart4();
        send4(1, 15, 15, 224);
        send4(1, 3, 3, 12);
        send4(1, 2, 2, 4);
        if (bus4.err_count !== 9'd2 || bus4.max_ed !== 8'd3 || bus4.sum_ed !== 17'd4 || bus4.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mix_partial err=%0d max=%0d sum=%0d done=%b expected 2 3 4 0",
                     bus4.err_count, bus4.max_ed, bus4.sum_ed, bus4.done);
        end
        checks++;
        send4(1, 7, 9, 70);
        if (bus4.err_count !== 9'd3 || bus4.max_ed !== 8'd7 || bus4.sum_ed !== 17'd11 || bus4.done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mix_final err=%0d max=%0d sum=%0d done=%b expected 3 7 11 1",
                     bus4.err_count, bus4.max_ed, bus4.sum_ed, bus4.done);
        end
        checks++;
    endtask

    task automatic test_handshake();
        bit pattern [7] = '{1, 0, 0, 1, 1, 0, 1};
        int av [7] = '{5, 9, 9, 12, 1, 15, 6};
        int bv [7] = '{5, 9, 9, 11, 1, 15, 6};
        int pv [7] = '{20, 0, 0, 140, 1, 0, 40};
        pulseStart4();
        for (int i = 0; i < 7; i++) begin
            send4(pattern[i], av[i], bv[i], pv[i]);
            if (bus4.done !== (i == 6)) begin
                failures++;
                $display("[TB] FAIL hs_done cycle=%0d done=%b expected %b", i, bus4.done, (i == 6));
            end
            checks++;
        end
        if (mAcc !== NS || bus4.err_count !== 9'(mErr) || bus4.max_ed !== 8'(mMax) || bus4.sum_ed !== 17'(mSum)) begin
            failures++;
            $display("[TB] FAIL hs_stats acc=%0d err=%0d max=%0d sum=%0d expected %0d %0d %0d %0d",
                     mAcc, bus4.err_count, bus4.max_ed, bus4.sum_ed, NS, mErr, mMax, mSum);
        end
        checks++;
        send4(1, 15, 15, 0);
        send4(1, 15, 15, 0);
        if (bus4.done !== 1'b1 || bus4.err_count !== 9'(mErr) || bus4.sum_ed !== 17'(mSum) || bus4.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hs_hold_done done=%b err=%0d sum=%0d ready=%b expected 1 %0d %0d 0",
                     bus4.done, bus4.err_count, bus4.sum_ed, bus4.in_ready, mErr, mSum);
        end
        checks++;
    endtask

    task automatic test_ignored_start();
        pulseStart4();
        send4(1, 4, 4, 10);
        send4(1, 8, 2, 16);
        pulseStart4();
        if (bus4.busy !== 1'b1 || bus4.err_count !== 9'd1 || bus4.sum_ed !== 17'd6) begin
            failures++;
            $display("[TB] FAIL ign_start_mid busy=%b err=%0d sum=%0d expected 1 1 6",
                     bus4.busy, bus4.err_count, bus4.sum_ed);
        end
        checks++;
        send4(1, 3, 5, 17);
        send4(1, 10, 10, 90);
        if (bus4.done !== 1'b1 || bus4.err_count !== 9'd3 || bus4.max_ed !== 8'd10 || bus4.sum_ed !== 17'd18) begin
            failures++;
            $display("[TB] FAIL ign_start_final done=%b err=%0d max=%0d sum=%0d expected 1 3 10 18",
                     bus4.done, bus4.err_count, bus4.max_ed, bus4.sum_ed);
        end
        checks++;
        pulseStart4();
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0 || bus4.err_count !== 9'd0 ||
            bus4.max_ed !== 8'd0 || bus4.sum_ed !== 17'd0) begin
            failures++;
            $display("[TB] FAIL restart busy=%b done=%b err=%0d max=%0d sum=%0d expected 1 0 0 0 0",
                     bus4.busy, bus4.done, bus4.err_count, bus4.max_ed, bus4.sum_ed);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int run = 0; run < 8; run++) begin
            int cyc = 0;
            pulseStart4();
            while (mRun && cyc < 200) begin
                int a = $urandom_range(0, 15);
                int b = $urandom_range(0, 15);
                int p = ($urandom_range(0, 2) == 0) ? a * b : $urandom_range(0, 255);
                send4($urandom_range(0, 1) == 1, a, b, p);
                cyc++;
            end
            if (mRun || bus4.done !== 1'b1 || bus4.err_count !== 9'(mErr) ||
                bus4.max_ed !== 8'(mMax) || bus4.sum_ed !== 17'(mSum)) begin
                failures++;
                $display("[TB] FAIL rand_run%0d done=%b err=%0d max=%0d sum=%0d expected 1 %0d %0d %0d",
                         run, bus4.done, bus4.err_count, bus4.max_ed, bus4.sum_ed, mErr, mMax, mSum);
            end
            checks++;
        end
    endtask

    task automatic test_bound();
        bus256.start = 1'b1;
        tick();
        bus256.start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus256.in_valid = 1'b1;
            bus256.in1      = 4'd0;
            bus256.in2      = 4'd0;
            bus256.prod     = 8'd255;
            tick();
            if (i == 254) begin
                if (bus256.done !== 1'b0 || bus256.err_count !== 9'd255) begin
                    failures++;
                    $display("[TB] FAIL bound_early done=%b err=%0d expected 0 255", bus256.done, bus256.err_count);
                end
                checks++;
            end
        end
        bus256.in_valid = 1'b0;
        if (bus256.done !== 1'b1 || bus256.err_count !== 9'd256 || bus256.max_ed !== 8'd255 ||
            bus256.sum_ed !== 17'd65280) begin
            failures++;
            $display("[TB] FAIL bound_final done=%b err=%0d max=%0d sum=%0d expected 1 256 255 65280",
                     bus256.done, bus256.err_count, bus256.max_ed, bus256.sum_ed);
        end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        mRun  = 1'b0;
        mErr = 0; mMax = 0; mSum = 0; mAcc = 0;
        bus4.start = 1'b0;   bus4.in_valid = 1'b0;   bus4.in1 = '0;   bus4.in2 = '0;   bus4.prod = '0;
        bus256.start = 1'b0; bus256.in_valid = 1'b0; bus256.in1 = '0; bus256.in2 = '0; bus256.prod = '0;
        test_reset();
        test_exact_stream();
        test_error_mix();
        test_handshake();
        test_ignored_start();
        test_random();
        test_bound();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
